// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: access codes, FSM encoding, strobes.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [STRB_W-1:0] STRB_B    = 4'b0001;
    localparam logic [STRB_W-1:0] STRB_H_LO = 4'b0011;
    localparam logic [STRB_W-1:0] STRB_H_HI = 4'b1100;
    localparam logic [STRB_W-1:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational load/store alignment unit.
//   addr_lo/funct3/rs2_data : current access -> wstrb_c, wdata_c, misalign_c
//   ld_off/ld_funct3/rdata  : latched load info + returned word -> ld_data_c
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    input  logic [WORD_W-1:0] rs2_data,
    input  logic [1:0]        ld_off,
    input  logic [2:0]        ld_funct3,
    input  logic [WORD_W-1:0] rdata,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [WORD_W-1:0] wdata_c,
    output logic              misalign_c,
    output logic [WORD_W-1:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misalignment: halfword on odd byte, word off a 4-byte boundary
    assign misalign_c = ((funct3[1:0] == SZ_H) && addr_lo[0]) ||
                        ((funct3[1:0] == SZ_W) && (addr_lo != 2'b00));

    // Store lane replication and byte enables
    always_comb begin
        wstrb_c = '0;
        wdata_c = rs2_data;
        case (funct3)
            F3_SB: begin
                wstrb_c = STRB_B << addr_lo;
                wdata_c = {4{rs2_data[7:0]}};
            end
            F3_SH: begin
                wstrb_c = addr_lo[1] ? STRB_H_HI : STRB_H_LO;
                wdata_c = {2{rs2_data[15:0]}};
            end
            F3_SW: begin
                wstrb_c = STRB_WORD;
                wdata_c = rs2_data;
            end
            default: ;
        endcase
    end

    // Load lane select and extension
    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];

        ld_data_c = rdata;
        case (ld_funct3)
            F3_LB:   ld_data_c = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data_c = {24'd0, ld_byte};
            F3_LH:   ld_data_c = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data_c = {16'd0, ld_half};
            default: ld_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the dual-issue pipeline. Issue A performs loads/stores over a
// valid/ready request channel with a variable-latency response; issue B passes through.
//   Inputs : iA_* / iB_* from EX/MEM, flush, dmem_req_ready, dmem_rsp_valid, dmem_rdata
//   Outputs: dmem_req_* (combinational), stall (combinational), misalign pulse,
//            oA_* / oB_* MEM/WB buffer
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   iA_alu_out,
    input  logic [XLEN-1:0]   iA_rs2_data,
    input  logic [4:0]        iA_rd_addr,
    input  logic              iA_reg_write,
    input  logic              iA_mem_read,
    input  logic              iA_mem_write,
    input  logic [2:0]        iA_funct3,
    input  logic [XLEN-1:0]   iB_alu_out,
    input  logic [4:0]        iB_rd_addr,
    input  logic              iB_reg_write,
    input  logic              flush,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stall,
    output logic              misalign,
    output logic [XLEN-1:0]   oA_wb_data,
    output logic [4:0]        oA_rd_addr,
    output logic              oA_reg_write,
    output logic [XLEN-1:0]   oB_wb_data,
    output logic [4:0]        oB_rd_addr,
    output logic              oB_reg_write
);

    mem_state_t  state, state_nxt;
    logic [1:0]  ld_off;
    logic [2:0]  ld_f3;
    logic        mem_op;
    logic        mis_c;
    logic        kill;
    logic        a_take;
    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   ld_data_c;

    assign mem_op     = iA_mem_read | iA_mem_write;
    assign dmem_addr  = ADDR_W'({iA_alu_out[XLEN-1:2], 2'b00});
    assign dmem_we    = iA_mem_write;
    assign dmem_wstrb = iA_mem_write ? wstrb_c : '0;

    mem_stage_lsu_align u_align (
        .addr_lo    (iA_alu_out[1:0]),
        .funct3     (iA_funct3),
        .rs2_data   (iA_rs2_data),
        .ld_off     (ld_off),
        .ld_funct3  (ld_f3),
        .rdata      (dmem_rdata),
        .wstrb_c    (wstrb_c),
        .wdata_c    (dmem_wdata),
        .misalign_c (mis_c),
        .ld_data_c  (ld_data_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, request and stall; all quiet while in reset
    always_comb begin
        state_nxt      = state;
        dmem_req_valid = 1'b0;
        stall          = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (mem_op && !mis_c && !flush) begin
                        dmem_req_valid = 1'b1;
                        if (!dmem_req_ready) begin
                            stall = 1'b1;
                        end else if (!iA_mem_write) begin
                            stall     = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_rsp_valid) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                        if (flush) state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_rsp_valid) state_nxt = ST_IDLE;
                    else                stall     = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Offset and size captured at accept so extraction is independent of later inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_off <= '0;
            ld_f3  <= '0;
        end else if (dmem_req_valid && dmem_req_ready) begin
            ld_off <= iA_alu_out[1:0];
            ld_f3  <= iA_funct3;
        end
    end

    // A draining load belongs to a flushed instruction, so it kills like flush does
    assign kill   = flush | (state == ST_DRAIN);
    // Issue A writes back only as a completing load or as a plain ALU op
    assign a_take = (state == ST_WAIT) | !mem_op;

    // MEM/WB buffer; stalled cycles insert bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oA_wb_data   <= '0;
            oA_rd_addr   <= '0;
            oA_reg_write <= 1'b0;
            oB_wb_data   <= '0;
            oB_rd_addr   <= '0;
            oB_reg_write <= 1'b0;
            misalign     <= 1'b0;
        end else if (stall) begin
            oA_reg_write <= 1'b0;
            oB_reg_write <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            oA_wb_data   <= (state == ST_WAIT) ? ld_data_c : iA_alu_out;
            oA_rd_addr   <= kill ? 5'd0 : iA_rd_addr;
            oA_reg_write <= iA_reg_write & a_take & !kill;
            oB_wb_data   <= iB_alu_out;
            oB_rd_addr   <= kill ? 5'd0 : iB_rd_addr;
            oB_reg_write <= iB_reg_write & !kill;
            misalign     <= (state == ST_IDLE) & mem_op & mis_c & !flush;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk, rst;
    logic [31:0] iA_alu_out, iA_rs2_data, iB_alu_out, dmem_rdata;
    logic [4:0]  iA_rd_addr, iB_rd_addr;
    logic        iA_reg_write, iA_mem_read, iA_mem_write, iB_reg_write, flush;
    logic [2:0]  iA_funct3;
    logic        dmem_req_ready, dmem_rsp_valid;
    logic        dmem_req_valid, dmem_we, stall, misalign;
    logic [31:0] dmem_addr, dmem_wdata, oA_wb_data, oB_wb_data;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  oA_rd_addr, oB_rd_addr;
    logic        oA_reg_write, oB_reg_write;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .iA_alu_out(iA_alu_out), .iA_rs2_data(iA_rs2_data), .iA_rd_addr(iA_rd_addr),
        .iA_reg_write(iA_reg_write), .iA_mem_read(iA_mem_read), .iA_mem_write(iA_mem_write),
        .iA_funct3(iA_funct3), .iB_alu_out(iB_alu_out), .iB_rd_addr(iB_rd_addr),
        .iB_reg_write(iB_reg_write), .flush(flush),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .stall(stall), .misalign(misalign),
        .oA_wb_data(oA_wb_data), .oA_rd_addr(oA_rd_addr), .oA_reg_write(oA_reg_write),
        .oB_wb_data(oB_wb_data), .oB_rd_addr(oB_rd_addr), .oB_reg_write(oB_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a_alu;
        logic [31:0] a_rs2;
        logic [4:0]  a_rd;
        logic        a_rw, a_mr, a_mw;
        logic [2:0]  f3;
        logic [31:0] b_alu;
        logic [4:0]  b_rd;
        logic        b_rw, fl;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [31:0] e_awb;
        logic [4:0]  e_ard;
        logic        e_arw;
        logic [4:0]  e_brd;
        logic        e_brw, e_mis;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        iA_alu_out = alu; iA_rs2_data = rs2; iA_rd_addr = rd;
        iA_reg_write = rw; iA_mem_read = mr; iA_mem_write = mw; iA_funct3 = f3;
    endtask

    task automatic drive_b(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        iB_alu_out = alu; iB_rd_addr = rd; iB_reg_write = rw;
    endtask

    // Load with ready_dly unready cycles, then rsp_dly cycles in WAIT before the response
    task automatic run_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                            input int ready_dly, input int rsp_dly,
                            input logic [31:0] rdata, input logic [31:0] exp);
        drive_a(addr, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, f3);
        drive_b(32'h99, 5'd11, 1'b1);
        dmem_req_ready = 1'b0;
        for (int i = 0; i < ready_dly; i++) begin
            #1;
            chk({nm, " req_pending"}, 32'(dmem_req_valid), 32'd1);
            chk({nm, " stall_pending"}, 32'(stall), 32'd1);
            tick();
            chk({nm, " bubbleA_pending"}, 32'(oA_reg_write), 32'd0);
            chk({nm, " bubbleB_pending"}, 32'(oB_reg_write), 32'd0);
        end
        dmem_req_ready = 1'b1;
        #1;
        chk({nm, " req_accept"}, 32'(dmem_req_valid), 32'd1);
        chk({nm, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({nm, " we"}, 32'(dmem_we), 32'd0);
        chk({nm, " stall_accept"}, 32'(stall), 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            #1;
            chk({nm, " stall_wait"}, 32'(stall), 32'd1);
            chk({nm, " req_wait"}, 32'(dmem_req_valid), 32'd0);
            tick();
            chk({nm, " bubbleA_wait"}, 32'(oA_reg_write), 32'd0);
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk({nm, " stall_rsp"}, 32'(stall), 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        chk({nm, " wb_data"}, oA_wb_data, exp);
        chk({nm, " rd"}, 32'(oA_rd_addr), 32'd10);
        chk({nm, " rw"}, 32'(oA_reg_write), 32'd1);
        chk({nm, " b_data"}, oB_wb_data, 32'h99);
        chk({nm, " b_rw"}, 32'(oB_reg_write), 32'd1);
        drive_a(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive_b(32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        drive_a(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive_b(32'd0, 5'd0, 1'b0);

        //        a_alu         a_rs2         rd  rw mr mw f3      b_alu     brd brw fl  req e_addr      strb     wdata         stl awb           ard arw brd brw mis
        vecs[0]  = '{32'h1234,    32'h0,        5,  1, 0, 0, 3'd0,  32'h55,  6,  1, 0,  0, 32'h0,     4'h0, 32'h0,        0, 32'h1234,    5,  1,  6,  1,  0};
        vecs[1]  = '{32'h103,     32'hAB,       0,  0, 0, 1, F3_SB, 32'h77,  7,  1, 0,  1, 32'h100,   4'h8, 32'hABABABAB, 0, 32'h103,     0,  0,  7,  1,  0};
        vecs[2]  = '{32'h202,     32'h1234BEEF, 0,  0, 0, 1, F3_SH, 32'h78,  8,  1, 0,  1, 32'h200,   4'hC, 32'hBEEFBEEF, 0, 32'h202,     0,  0,  8,  1,  0};
        vecs[3]  = '{32'h30C,     32'hDEADBEEF, 0,  0, 0, 1, F3_SW, 32'h0,   0,  0, 0,  1, 32'h30C,   4'hF, 32'hDEADBEEF, 0, 32'h30C,     0,  0,  0,  0,  0};
        vecs[4]  = '{32'h6,       32'h0,        9,  1, 1, 0, F3_LW, 32'h33,  12, 1, 0,  0, 32'h0,     4'h0, 32'h0,        0, 32'h6,       9,  0,  12, 1,  1};
        vecs[5]  = '{32'hCAFE,    32'h0,        3,  1, 0, 0, 3'd0,  32'h1,   4,  1, 0,  0, 32'h0,     4'h0, 32'h0,        0, 32'hCAFE,    3,  1,  4,  1,  0};
        vecs[6]  = '{32'h101,     32'h0,        2,  1, 1, 0, F3_LH, 32'h0,   0,  0, 0,  0, 32'h0,     4'h0, 32'h0,        0, 32'h101,     2,  0,  0,  0,  1};
        vecs[7]  = '{32'h102,     32'h5,        0,  0, 0, 1, F3_SW, 32'h0,   0,  0, 0,  0, 32'h0,     4'h0, 32'h0,        0, 32'h102,     0,  0,  0,  0,  1};
        vecs[8]  = '{32'h88,      32'h0,        8,  1, 0, 0, 3'd0,  32'h99,  9,  1, 1,  0, 32'h0,     4'h0, 32'h0,        0, 32'h88,      0,  0,  0,  0,  0};
        vecs[9]  = '{32'h400,     32'h1,        0,  0, 0, 1, F3_SW, 32'h0,   0,  0, 1,  0, 32'h0,     4'h0, 32'h0,        0, 32'h400,     0,  0,  0,  0,  0};
        vecs[10] = '{32'h100,     32'h12345678, 0,  0, 0, 1, F3_SB, 32'h5,   5,  1, 0,  1, 32'h100,   4'h1, 32'h78787878, 0, 32'h100,     0,  0,  5,  1,  0};
        vecs[11] = '{32'h204,     32'h0000CAFE, 0,  0, 0, 1, F3_SH, 32'h0,   0,  0, 0,  1, 32'h204,   4'h3, 32'hCAFECAFE, 0, 32'h204,     0,  0,  0,  0,  0};
        vecs[12] = '{32'h1,       32'h0,        1,  0, 0, 0, 3'd0,  32'h2,   2,  1, 0,  0, 32'h0,     4'h0, 32'h0,        0, 32'h1,       1,  0,  2,  1,  0};

        #12;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst oA_wb_data", oA_wb_data, 32'd0);
        chk("rst oA_reg_write", 32'(oA_reg_write), 32'd0);
        chk("rst oB_reg_write", 32'(oB_reg_write), 32'd0);
        chk("rst misalign", 32'(misalign), 32'd0);
        tick();
        rst = 1'b0;

        dmem_req_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive_a(vecs[i].a_alu, vecs[i].a_rs2, vecs[i].a_rd, vecs[i].a_rw,
                    vecs[i].a_mr, vecs[i].a_mw, vecs[i].f3);
            drive_b(vecs[i].b_alu, vecs[i].b_rd, vecs[i].b_rw);
            flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d req_valid", i), 32'(dmem_req_valid), 32'(vecs[i].e_req));
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(vecs[i].a_mw));
                chk($sformatf("v%0d wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].e_strb));
                chk($sformatf("v%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
            end
            tick();
            chk($sformatf("v%0d oA_wb_data", i), oA_wb_data, vecs[i].e_awb);
            chk($sformatf("v%0d oA_rd_addr", i), 32'(oA_rd_addr), 32'(vecs[i].e_ard));
            chk($sformatf("v%0d oA_reg_write", i), 32'(oA_reg_write), 32'(vecs[i].e_arw));
            chk($sformatf("v%0d oB_wb_data", i), oB_wb_data, vecs[i].b_alu);
            chk($sformatf("v%0d oB_rd_addr", i), 32'(oB_rd_addr), 32'(vecs[i].e_brd));
            chk($sformatf("v%0d oB_reg_write", i), 32'(oB_reg_write), 32'(vecs[i].e_brw));
            chk($sformatf("v%0d misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
        end
        flush = 1'b0;

        // Loads: stalls, latency and extraction
        run_load("LB",  32'h102, F3_LB,  2, 3, 32'h00F00000, 32'hFFFFFFF0);
        run_load("LBU", 32'h102, F3_LBU, 0, 0, 32'h00F00000, 32'h000000F0);
        run_load("LH",  32'h102, F3_LH,  1, 1, 32'h80010000, 32'hFFFF8001);
        run_load("LHU", 32'h102, F3_LHU, 0, 2, 32'h80010000, 32'h00008001);
        run_load("LW",  32'h208, F3_LW,  0, 0, 32'h13579BDF, 32'h13579BDF);

        // Flush in WAIT: drain the response, no writeback
        drive_a(32'h40, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, F3_LW);
        drive_b(32'h44, 5'd13, 1'b1);
        dmem_req_ready = 1'b1;
        #1; chk("drain stall_accept", 32'(stall), 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        flush = 1'b1;
        #1; chk("drain stall_flush", 32'(stall), 32'd1);
        tick();
        chk("drain bubbleA", 32'(oA_reg_write), 32'd0);
        flush = 1'b0;
        #1; chk("drain stall_drain", 32'(stall), 32'd1);
        chk("drain req_drain", 32'(dmem_req_valid), 32'd0);
        tick();
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h11111111;
        #1; chk("drain stall_rsp", 32'(stall), 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        chk("drain oA_reg_write", 32'(oA_reg_write), 32'd0);
        chk("drain oB_reg_write", 32'(oB_reg_write), 32'd0);
        drive_a(32'h77, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0);
        drive_b(32'h0, 5'd0, 1'b0);
        #1; chk("drain idle_stall", 32'(stall), 32'd0);
        tick();
        chk("drain idle_wb", oA_wb_data, 32'h77);
        chk("drain idle_rw", 32'(oA_reg_write), 32'd1);

        // Flush coincident with response
        drive_a(32'h50, 32'd0, 5'd14, 1'b1, 1'b1, 1'b0, F3_LW);
        drive_b(32'h55, 5'd15, 1'b1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        flush = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h22222222;
        #1; chk("flrsp stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0; dmem_rsp_valid = 1'b0;
        chk("flrsp oA_reg_write", 32'(oA_reg_write), 32'd0);
        chk("flrsp oB_reg_write", 32'(oB_reg_write), 32'd0);

        // Reset while waiting on a load
        drive_a(32'hABCD, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        drive_b(32'h1111, 5'd4, 1'b1);
        tick();
        chk("rstw pre_wb", oA_wb_data, 32'hABCD);
        drive_a(32'h80, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0, F3_LW);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstw oA_wb_data", oA_wb_data, 32'd0);
        chk("rstw oB_wb_data", oB_wb_data, 32'd0);
        chk("rstw oA_rd_addr", 32'(oA_rd_addr), 32'd0);
        chk("rstw stall", 32'(stall), 32'd0);
        chk("rstw req_valid", 32'(dmem_req_valid), 32'd0);
        tick();
        rst = 1'b0;
        drive_a(32'h5A, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFF;
        #1; chk("rstw late_stall", 32'(stall), 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        chk("rstw late_wb", oA_wb_data, 32'h5A);
        chk("rstw late_rw", 32'(oA_reg_write), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the dual-issue RV32 pipeline; sits directly downstream of the execute stage's EX/MEM buffer and feeds writeback.
- Issue A may carry a load or store, issued to data memory over a valid/ready request channel with a variable-latency response.
- Issue B is ALU-only and passes through.
- Owns the MEM/WB pipeline buffer for both issues and raises stall while a memory access is outstanding.

Parameters:
XLEN, 32, datapath width
ADDR_W, 32, data-memory byte-address width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
iA_alu_out  in  32  issue A ALU result / effective address
iA_rs2_data  in  32  issue A store data
iA_rd_addr  in  5  issue A destination register
iA_reg_write  in  1  issue A writes rd
iA_mem_read  in  1  issue A is a load
iA_mem_write  in  1  issue A is a store
iA_funct3  in  3  access size/sign (RV32I load/store funct3)
iB_alu_out  in  32  issue B ALU result
iB_rd_addr  in  5  issue B destination register
iB_reg_write  in  1  issue B writes rd
flush  in  1  kill both issues currently in MEM
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
dmem_we  out  1  1 = store, 0 = load
dmem_wstrb  out  4  store byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rsp_valid  in  1  load data valid, one cycle
dmem_rdata  in  32  load word
stall  out  1  hold upstream stages (combinational)
misalign  out  1  registered one-cycle pulse on misaligned access
oA_wb_data  out  32  issue A writeback value
oA_rd_addr  out  5  issue A destination register
oA_reg_write  out  1  issue A write enable
oB_wb_data  out  32  issue B writeback value
oB_rd_addr  out  5  issue B destination register
oB_reg_write  out  1  issue B write enable

Behaviour:
- Reset (async, rst=1): state IDLE; every registered output 0; dmem_req_valid=0; stall=0.
- mem_op = iA_mem_read | iA_mem_write.
- Misaligned:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Upstream holds all inputs stable while stall=1.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE, no mem_op or flush: no request. MEM/WB captures next edge: 1-cycle latency.
  - oA_wb_data=iA_alu_out; oB_wb_data=iB_alu_out.
  - Write enables gated by !flush; rd fields are 0 on flush.
- IDLE, misaligned mem_op:
  - no request, no stall;
  - oA_reg_write<=0; misalign<=1 for one cycle;
  - issue B proceeds normally.
- IDLE, aligned mem_op, !flush:
  - dmem_req_valid=1, held until dmem_req_ready;
  - stall=1 while unaccepted.
- Store accepted (valid & ready):
  - stall=0 that cycle; buffers capture; oA_reg_write<=0; stay IDLE.
- Load accepted: go to WAIT, stall=1.
- While stalled:
  - oA_reg_write<=0 and oB_reg_write<=0 each edge (bubbles into WB);
  - request fields stable.
- WAIT, dmem_rsp_valid:
  - stall=0;
  - oA_wb_data<=extracted load value; oA_reg_write<=iA_reg_write;
  - issue B captured the same edge;
  - go to IDLE.
- Minimum load latency is 2 cycles: accept, then response.
- Load extraction by addr[1:0]:
  - LB/LBU select a byte; LH/LHU select the halfword by addr[1];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store formatting:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: wstrb=4'b1111, wdata=rs2.
- Offset and funct3 are latched at request accept; extraction uses the latched copy.
- Flush in IDLE before accept: request withdrawn the same cycle (valid gated by !flush); bubbles written.
- Flush in WAIT without rsp_valid:
  - go to DRAIN; stall stays 1;
  - on rsp_valid, discard the data, go to IDLE, stall=0.
- Flush in WAIT coincident with rsp_valid: data discarded, both write enables 0, go to IDLE.
- rsp_valid in IDLE is ignored.
- Reset mid-WAIT: return to IDLE immediately; the late response is ignored.
- Only one outstanding request at a time.

Decomposition:
- Shared package (pipeline defines):
  - funct3 codes LB/LH/LW/LBU/LHU, SB/SH/SW;
  - FSM encodings IDLE/WAIT/DRAIN;
  - strobe constants.
- One combinational sub-module, lsu_align:
  - store lane/strobe formatting;
  - load extract/sign-extend;
  - misalign detect.

Test Plan:
- ALU-only: iA_alu_out=0x1234, iB_alu_out=0x55, both reg_write=1, rd=5/6 -> next cycle oA_wb_data=0x1234 (rd 5), oB_wb_data=0x55 (rd 6), stall never asserts.
- SB, addr=0x103, rs2=0xAB, ready=1 -> wstrb=4'b1000, wdata=0xABABABAB, dmem_addr=0x100, stall=0, oA_reg_write=0.
- LB, addr=0x102, ready after 2 cycles, rsp after 3 more cycles with rdata=0x00F00000 -> stall high throughout, then oA_wb_data=0xFFFFFFF0; with LBU instead, 0x000000F0.
- LW, addr=0x006 -> no dmem_req_valid, misalign pulse of 1 cycle, oA_reg_write=0, no stall.
- LW accepted, flush in WAIT, rsp 2 cycles later -> DRAIN, stall held until rsp, data discarded, no writeback.
- rst asserted mid-WAIT -> all outputs 0 immediately; a rsp_valid after reset release causes no writeback.
